// File: rtl/fifo_umbrales_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_umbrales_pkg
// Purpose  : Shared widths and the occupancy-update encoding for fifo_umbrales.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_umbrales_pkg;

    localparam int c_data_width_def    = 6;
    localparam int c_address_width_def = 2;

    // Occupancy update chosen per cycle from the accepted transfers.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    function automatic cnt_op_e count_op(input logic wr_acc, input logic rd_acc);
        cnt_op_e op;
        op = CNT_HOLD;
        if (wr_acc && !rd_acc) begin
            op = CNT_INC;
        end else if (rd_acc && !wr_acc) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_umbrales_memoria_fifo.sv
`default_nettype none
// ============================================================================
// Module   : memoria_fifo
// Purpose  : DEPTH x DATA_WIDTH register array, one sync write, one registered read.
// Revision : 1.0 - initial release
// ============================================================================
module memoria_fifo
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH    = c_data_width_def,
    parameter int ADDRESS_WIDTH = c_address_width_def
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int c_depth = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [c_depth];
    logic [DATA_WIDTH-1:0] mem_d [c_depth];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Read sees the pre-edge contents, so a same-address write never bypasses.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fifo_umbrales.sv
`default_nettype none
// ============================================================================
// Module   : fifo_umbrales
// Purpose  : Synchronous FIFO with occupancy count, runtime thresholds and
//            sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_umbrales
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH    = c_data_width_def,
    parameter int ADDRESS_WIDTH = c_address_width_def
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_enable,
    input  logic                     rd_enable,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [ADDRESS_WIDTH:0]   umbral_almost_full,
    input  logic [ADDRESS_WIDTH:0]   umbral_almost_empty,
    input  logic                     error_clear,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    output logic                     full_fifo,
    output logic                     empty_fifo,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     error,
    output logic [ADDRESS_WIDTH:0]   count
);

    localparam int                 c_cnt_w = ADDRESS_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(2 ** ADDRESS_WIDTH);

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]       count_q, count_d;
    logic                     valid_out_q, valid_out_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;

    logic    wr_accept;
    logic    rd_accept;
    logic    wr_reject;
    logic    rd_reject;
    cnt_op_e cnt_op;

    // Full/empty come from the count; pointers alone cannot tell them apart.
    assign full_fifo  = (count_q == c_depth);
    assign empty_fifo = (count_q == '0);

    // When full, a concurrent read frees the slot the write lands in.
    assign rd_accept = rd_enable && !empty_fifo;
    assign wr_accept = wr_enable && (!full_fifo || rd_accept);
    assign wr_reject = wr_enable && !wr_accept;
    assign rd_reject = rd_enable && empty_fifo;
    assign cnt_op    = count_op(wr_accept, rd_accept);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        valid_out_d = rd_accept;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (cnt_op)
            CNT_INC: count_d = count_q + 1'b1;
            CNT_DEC: count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event in the clearing cycle keeps its bit set.
        if (error_clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_reject) begin
            overflow_d = 1'b1;
        end
        if (rd_reject) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    memoria_fifo #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_memoria_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    // Thresholds above DEPTH are used as-is, without clamping.
    assign almost_full  = (count_q >= umbral_almost_full);
    assign almost_empty = (count_q <= umbral_almost_empty);
    assign valid_out    = valid_out_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign error        = overflow_q | underflow_q;
    assign count        = count_q;

endmodule
`default_nettype wire
